avg_datapath: RTL
=================

# avg_datapath

Register-file datapath that executes the micro-operations issued each cycle by the four-sample averaging controller. It holds the sample, sort and partial-sum registers, and performs LOAD, COPY and ADD. It reports signed overflow combinationally so the controller can branch in the same cycle, and produces the registered four-sample average with a one-cycle valid strobe.

## Interface
- DATA_W, 16, sample/register width, signed two's complement
- NREG, 16, number of registers; addressed by 4-bit src1/src2/dest
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- op  in  2  micro-op: 00 NOP, 01 COPY, 10 LOAD, 11 ADD
- src1  in  4  first operand register index
- src2  in  4  second operand register index (ADD only)
- dest  in  4  destination register index
- ext_data  in  DATA_W  incoming sample, consumed by LOAD
- overflow  out  1  combinational signed-add overflow of the current ADD
- ovf_sticky  out  1  registered; set on any ADD overflow, cleared only by reset
- avg_out  out  DATA_W  registered average (final sum >>> 2)
- avg_valid  out  1  registered one-cycle strobe marking a new avg_out
- avg_count  out  16  registered count of averages produced, saturating

## Operation
- Register file: NREG x DATA_W flops. Reads are combinational from the current contents. Writes occur at the rising clk edge.
- NOP: no register written. avg_valid is low the next cycle.
- COPY: reg[dest] <= reg[src1]. src2 is ignored. COPY with src1 == dest leaves the register unchanged.
- LOAD: reg[dest] <= ext_data. src1 and src2 are ignored.
- ADD: sum = reg[src1] + reg[src2], truncated to DATA_W, then reg[dest] <= sum.
  - The write happens even when it overflows; the wrapped value is stored.
- overflow = (op == 11) && (reg[src1][MSB] == reg[src2][MSB]) && (sum[MSB] != reg[src1][MSB]).
  - overflow is 0 for every other op.
  - overflow is purely combinational with no register in the path. The controller samples it in the same cycle.
- ovf_sticky <= ovf_sticky | overflow on every edge.
- Average completion: the controller's final ADD writes dest = 0. An ADD with dest == 0 and overflow == 0 causes:
  - avg_out <= sum >>> 2 (arithmetic shift, floor toward negative infinity)
  - avg_valid <= 1
  - avg_count <= avg_count + 1, holding at 16'hFFFF
- An ADD with dest == 0 and overflow == 1 writes reg[0] but leaves avg_out, avg_valid and avg_count unchanged. avg_valid is low.
- ADD or COPY into any dest other than 0 never touches avg_out.
- Same-cycle read/write of one index (e.g. src1 == dest): the operand is the pre-edge value. No forwarding is needed, because the write is visible only from the next cycle.

## Timing
- Reset (synchronous, reset high at an edge):
  - all registers 0
  - avg_out 0, avg_valid 0, avg_count 0, ovf_sticky 0
  - overflow then evaluates to 0 for any ADD, since 0 + 0 cannot overflow
- Reset has priority over any op in the same cycle. An op presented in a reset cycle is discarded.
- Reset asserted mid-sequence (e.g. between the sort COPYs and the ADDs) discards all partial results. No avg_valid follows.
- Latency: a result written at edge N is readable combinationally in cycle N+1.
  - avg_out/avg_valid update at the same edge that writes reg[0].
  - avg_valid is high for exactly the one cycle after that edge.
- Back-to-back final ADDs on consecutive cycles produce back-to-back avg_valid pulses, each with its own avg_out.
- There is no stall or backpressure. The controller holds modwait high while this block is mid-sequence. The datapath executes exactly one op per cycle.

## Test plan
- Reset check: assert reset with op=10, ext_data=16'h1234, dest=5 -> next cycle reg[5]=0, avg_out=0, avg_valid=0, avg_count=0, ovf_sticky=0.
- Full average: LOAD 10, 20, 30, 40 into regs 1-4. Then ADD 1+2->6, ADD 3+4->7, ADD 6+7->0.
  - overflow stays 0 throughout.
  - Final edge gives avg_out=25, avg_valid=1 for one cycle, avg_count=1.
- Negative floor: regs 1-4 = -1, -2, -3, -3 (sum -9) -> avg_out=16'hFFFD (-3), avg_valid=1.
- Overflow branch: reg6=16'h7FFF, reg7=16'h0001, ADD 6+7->0.
  - overflow=1 in that cycle.
  - reg[0]=16'h8000 afterwards, ovf_sticky=1.
  - avg_valid=0, avg_count unchanged.
  - A later reset clears ovf_sticky.
- COPY chain / read-before-write: reg2=7, reg3=9; COPY 3->2 and then COPY 2->1 on consecutive cycles -> reg2=9, reg1=9. Same-cycle COPY 2->2 leaves reg2=9.
- Saturation: preload avg_count to 16'hFFFE via repeated averages (or force in the bench), then run two completions -> avg_count reads FFFF after both, and avg_valid still pulses each time.

Source files
------------

// File: rtl/avg_datapath.sv
// avg_datapath: register-file datapath executing NOP/COPY/LOAD/ADD for the four-sample averager
module avg_datapath #(
  parameter int DATA_W = 16,
  parameter int NREG   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        op,
  input  logic [3:0]        src1,
  input  logic [3:0]        src2,
  input  logic [3:0]        dest,
  input  logic [DATA_W-1:0] ext_data,
  output logic              overflow,
  output logic              ovf_sticky,
  output logic [DATA_W-1:0] avg_out,
  output logic              avg_valid,
  output logic [15:0]       avg_count
);
  localparam logic [1:0] OP_NOP = 2'b00, OP_COPY = 2'b01, OP_LOAD = 2'b10, OP_ADD = 2'b11;
  logic [DATA_W-1:0] rf_q [NREG];
  logic [DATA_W-1:0] a, b, sum, wr_data, avg_out_q, avg_out_d;
  logic [15:0]       avg_count_q, avg_count_d;
  logic              avg_valid_q, ovf_sticky_q, done, we;
  always_comb begin
    a         = rf_q[src1];
    b         = rf_q[src2];
    sum       = a + b;
    overflow  = (op == OP_ADD) && (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
    we        = op != OP_NOP;
    wr_data   = op == OP_LOAD ? ext_data : op == OP_COPY ? a : sum;
    // only a clean final ADD into reg 0 completes an average
    done      = (op == OP_ADD) && (dest == 4'd0) && !overflow;
    avg_out_d = done ? DATA_W'($signed(sum) >>> 2) : avg_out_q;
    avg_count_d = (done && avg_count_q != 16'hFFFF) ? avg_count_q + 16'd1 : avg_count_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_q         <= '{default: '0};
      avg_out_q    <= '0;
      avg_count_q  <= '0;
      avg_valid_q  <= 1'b0;
      ovf_sticky_q <= 1'b0;
    end else begin
      if (we) rf_q[dest] <= wr_data;
      avg_out_q    <= avg_out_d;
      avg_count_q  <= avg_count_d;
      avg_valid_q  <= done;
      ovf_sticky_q <= ovf_sticky_q | overflow;
    end
  end
  assign avg_out    = avg_out_q;
  assign avg_valid  = avg_valid_q;
  assign avg_count  = avg_count_q;
  assign ovf_sticky = ovf_sticky_q;
endmodule
